// File: rtl/dff_sweep_pkg.sv
// Shared types and lane-decode helpers for the CC_DFF sweep-bank sequencer.
// Lane k maps to parameter combination i = k >> 1; bit 0 of k selects the SR tie.
package dff_sweep_pkg;

    localparam int unsigned LANES = 64;

    typedef enum logic [3:0] {
        StIdle,
        StInitChk,
        StFlush,
        StApply,
        StRise,
        StRchk,
        StFall,
        StFchk,
        StDone
    } state_t;

    function automatic logic lane_clk_inv(input logic [5:0] k);
        return k[1];
    endfunction

    function automatic logic lane_en_inv(input logic [5:0] k);
        return k[2];
    endfunction

    function automatic logic lane_sr_eff(input logic [5:0] k);
        return k[0] ^ k[3];
    endfunction

    function automatic logic lane_sr_val(input logic [5:0] k);
        return k[4];
    endfunction

    function automatic logic lane_init(input logic [5:0] k);
        return k[5];
    endfunction

    // Fibonacci form, taps 16,14,13,11, shifting towards bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/dff_sweep_model.sv
// Bit-exact expected state of all 64 bank lanes, updated in lock-step with the
// stimulus the sequencer applies to the bank.
module dff_sweep_model
    import dff_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_init,
    input  logic             flush,
    input  logic             rise_upd,
    input  logic             fall_upd,
    input  logic             d,
    input  logic             en,
    output logic [LANES-1:0] model
);

    logic [LANES-1:0] model_d;
    logic [5:0]       lane;

    always_comb begin
        model_d = model;
        lane    = '0;
        for (int k = 0; k < LANES; k++) begin
            lane = 6'(k);
            if (lane_sr_eff(lane)) begin
                model_d[k] = lane_sr_val(lane);
            end else if (load_init) begin
                model_d[k] = lane_init(lane);
            end else if (flush) begin
                model_d[k] = 1'b0;
            end else if (((rise_upd && !lane_clk_inv(lane)) || (fall_upd && lane_clk_inv(lane)))
                         && (en ^ lane_en_inv(lane))) begin
                model_d[k] = d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model <= '0;
        end else begin
            model <= model_d;
        end
    end

endmodule

// File: rtl/dff_sweep_sequencer.sv
// Drives d/en/clk of the 64-lane DFF sweep bank from an LFSR, checks the synchronised
// bank outputs against the expected model after every bank edge, and latches the first miss.
module dff_sweep_sequencer
    import dff_sweep_pkg::*;
#(
    parameter int unsigned NUM_STEPS  = 16,
    parameter int unsigned SETTLE     = 3,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter bit          CHECK_INIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [5:0]       fail_lane,
    output logic [7:0]       fail_step,
    output logic             dut_d,
    output logic             dut_en,
    output logic             dut_clk,
    input  logic [LANES-1:0] dut_q
);

    localparam logic [15:0] SeedEff  = (LFSR_SEED == 16'h0) ? 16'h1 : LFSR_SEED;
    localparam logic [7:0]  SettleC  = 8'(SETTLE);
    localparam logic [7:0]  SettleM1 = 8'(SETTLE - 1);
    localparam logic [7:0]  NumSteps = 8'(NUM_STEPS);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [2:0]       fph_q, fph_d;
    logic [7:0]       step_q, step_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             first_run_q, first_run_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [5:0]       fail_lane_q, fail_lane_d;
    logic [7:0]       fail_step_q, fail_step_d;
    logic             d_q, d_d, en_q, en_d, clk_q, clk_d;
    logic [LANES-1:0] sync1_q, sync_q, model, mism;
    logic [5:0]       first_lane;
    logic             load_init, flush, rise_upd, fall_upd, compare, apply;

    dff_sweep_model u_model (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_init (load_init),
        .flush     (flush),
        .rise_upd  (rise_upd),
        .fall_upd  (fall_upd),
        .d         (d_q),
        .en        (en_q),
        .model     (model)
    );

    always_comb begin
        mism       = sync_q ^ model;
        first_lane = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (mism[k]) first_lane = 6'(k);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fph_d       = fph_q;
        step_d      = step_q;
        lfsr_d      = lfsr_q;
        first_run_d = first_run_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_lane_d = fail_lane_q;
        fail_step_d = fail_step_q;
        d_d         = d_q;
        en_d        = en_q;
        clk_d       = clk_q;
        load_init   = 1'b0;
        flush       = 1'b0;
        rise_upd    = 1'b0;
        fall_upd    = 1'b0;
        compare     = 1'b0;
        apply       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    busy_d      = 1'b1;
                    pass_d      = 1'b1;
                    fail_lane_d = '0;
                    fail_step_d = '0;
                    step_d      = '0;
                    first_run_d = 1'b0;
                    cnt_d       = '0;
                    fph_d       = '0;
                    d_d         = 1'b0;
                    en_d        = 1'b0;
                    if (CHECK_INIT && first_run_q) begin
                        state_d   = StInitChk;
                        load_init = 1'b1;
                    end else begin
                        state_d = StFlush;
                        flush   = 1'b1;
                    end
                end
            end
            StInitChk: begin
                if (cnt_q == SettleC) begin
                    compare = 1'b1;
                    flush   = 1'b1;
                    cnt_d   = '0;
                    state_d = StFlush;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StFlush: begin
                // Phases: low, high(en0), low(en0->1), high(en1), low settle before compare.
                if (fph_q == 3'd2 && cnt_q == 8'd0) en_d = 1'b1;
                if (cnt_q == SettleM1) begin
                    cnt_d = '0;
                    if (fph_q == 3'd4) begin
                        compare = 1'b1;
                        apply   = 1'b1;
                    end else begin
                        fph_d = fph_q + 3'd1;
                        clk_d = ~clk_q;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StApply: begin
                clk_d    = 1'b1;
                rise_upd = 1'b1;
                cnt_d    = '0;
                state_d  = StRise;
            end
            StRise: begin
                if (cnt_q == SettleM1) state_d = StRchk;
                else cnt_d = cnt_q + 8'd1;
            end
            StRchk: begin
                compare  = 1'b1;
                clk_d    = 1'b0;
                fall_upd = 1'b1;
                cnt_d    = '0;
                state_d  = StFall;
            end
            StFall: begin
                if (cnt_q == SettleM1) state_d = StFchk;
                else cnt_d = cnt_q + 8'd1;
            end
            StFchk: begin
                compare = 1'b1;
                if (step_q < NumSteps) begin
                    apply = 1'b1;
                end else begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    clk_d   = 1'b0;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Stimulus is set a full cycle before the rising edge so d/en never race dut_clk.
        if (apply) begin
            state_d = StApply;
            step_d  = step_q + 8'd1;
            d_d     = lfsr_q[0];
            en_d    = lfsr_q[1];
            lfsr_d  = lfsr_next(lfsr_q);
        end

        if (compare && pass_q && (|mism)) begin
            pass_d      = 1'b0;
            fail_lane_d = first_lane;
            fail_step_d = step_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            fph_q       <= '0;
            step_q      <= '0;
            lfsr_q      <= SeedEff;
            first_run_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_lane_q <= '0;
            fail_step_q <= '0;
            d_q         <= 1'b0;
            en_q        <= 1'b0;
            clk_q       <= 1'b0;
            sync1_q     <= '0;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fph_q       <= fph_d;
            step_q      <= step_d;
            lfsr_q      <= lfsr_d;
            first_run_q <= first_run_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_lane_q <= fail_lane_d;
            fail_step_q <= fail_step_d;
            d_q         <= d_d;
            en_q        <= en_d;
            clk_q       <= clk_d;
            sync1_q     <= dut_q;
            sync_q      <= sync1_q;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_lane = fail_lane_q;
    assign fail_step = fail_step_q;
    assign dut_d     = d_q;
    assign dut_en    = en_q;
    assign dut_clk   = clk_q;

endmodule

// File: doc/dff_sweep_sequencer.md
Name: dff_sweep_sequencer

Overview:
Self-checking stimulus sequencer for the 64-lane CC_DFF parameter-sweep bank. The bank has 32 parameter combinations, each with SR tied 0 and SR tied 1.
- Generates the bank's shared d/en/clock stimulus.
- Holds a bit-exact expected model of all 64 lanes.
- Compares sampled bank outputs after every bank clock edge.
- Reports pass/fail plus the first failing lane and step.
Sits between the on-chip test harness (start/done) and the DFF bank under test.

Parameters:
NUM_STEPS, 16, number of random stimulus steps per run (1..255); each step is one rise plus one fall of dut_clk.
SETTLE, 3, clk cycles dut_clk/d/en are held before dut_q is sampled (min 3; covers the 2-flop sync).
LFSR_SEED, 16'hACE1, nonzero seed of the 16-bit Fibonacci LFSR (taps 16,14,13,11); 0 is replaced by 1.
CHECK_INIT, 1, 1 = the first run after configuration checks INIT values before any bank clock edge.

Ports:
clk        in   1   system clock; all sequencer state on rising edge
rst_n      in   1   asynchronous active-low reset
start      in   1   pulse; begins a run when idle
busy       out  1   high from the start-accept cycle to the DONE entry
done       out  1   one-cycle pulse at run end
pass       out  1   result of the last run; valid while not busy
fail_lane  out  6   first mismatching lane index (k = 2*i + j)
fail_step  out  8   step of first mismatch (0 = INIT/flush check, n = step n)
dut_d      out  1   bank D, registered
dut_en     out  1   bank EN, registered
dut_clk    out  1   bank CLK, registered, toggled only by the FSM
dut_q      in   64  bank Q, asynchronous to clk; 2-flop synchronised inside

Behaviour:
- Reset values: busy=0, done=0, pass=0, fail_lane=0, fail_step=0, dut_d=0, dut_en=0, dut_clk=0.
  - LFSR reloads LFSR_SEED.
  - first_run flag is set to 1.
- Lane decode for lane k, with i=k>>1 and j=k[0]:
  - clk_inv=i[0], en_inv=i[1], sr_inv=i[2], sr_val=i[3], init=i[4].
  - sr_eff = j XOR sr_inv; en_eff = dut_en XOR en_inv.
- Expected model:
  - sr_eff=1: lane is constantly sr_val.
  - Otherwise the lane captures dut_d when en_eff=1 at the rising (clk_inv=0) or falling (clk_inv=1) dut_clk transition; else it holds.
- FSM states: IDLE, INIT_CHK, FLUSH, APPLY, RISE, RCHK, FALL, FCHK, DONE.
- IDLE:
  - start=1 goes to INIT_CHK if CHECK_INIT and first_run, else to FLUSH.
  - Accept cycle: busy=1, pass=1 (provisional), step=0, first_run clears.
  - start while busy is ignored.
- INIT_CHK: model = sr_eff ? sr_val : init. Wait SETTLE, compare, then go to FLUSH.
- FLUSH: d=0, two full dut_clk periods (en=0, then en=1), each half held SETTLE cycles.
  - Result: every sr_eff=0 lane is 0.
  - Compare after the last fall, then go to APPLY.
- APPLY: step++, dut_d=lfsr[0], dut_en=lfsr[1], LFSR advances. Hold 1 cycle, then go to RISE.
- RISE: dut_clk=1 and the model updates the clk_inv=0 lanes. Wait SETTLE, then go to RCHK.
- RCHK: compare (1 cycle), then go to FALL.
- FALL: dut_clk=0 and the model updates the clk_inv=1 lanes. Wait SETTLE, then go to FCHK.
- FCHK: compare, then go to APPLY if step<NUM_STEPS, else DONE.
- Per-step latency: 1 + 2*(SETTLE+1) clk cycles.
- Compare rule: mism = sync_q XOR model.
  - On the first nonzero mism of a run: pass=0, fail_lane = lowest set index, fail_step = step.
  - Later mismatches do not overwrite. The run continues to completion.
- DONE: done pulses 1 cycle, busy=0, dut_clk=0, then IDLE. d/en hold last values.
- rst_n mid-run:
  - Everything returns to reset values immediately, including dut_clk=0.
  - first_run=1, but the bank state is unknown, so INIT_CHK results after a mid-run reset are not meaningful. The harness must only reset before configuration-time starts.
- dut_clk never toggles except in FLUSH, RISE and FALL.

Decomposition:
- Package dff_sweep_pkg: FSM state enum, LANES=64 constant, and lane-decode functions (clk_inv, en_inv, sr_eff, sr_val, init of k).
- Sub-module dff_sweep_model:
  - Holds the 64-bit expected register.
  - Inputs: load_init, flush, rise_upd, fall_upd, d, en.
  - Output: model[63:0].

Test Plan:
- Ideal behavioural bank, defaults, start pulse → INIT_CHK, flush, 16 steps; done at the cycle count above; pass=1.
- Bank with lane 37 stuck-at-1 → pass=0, fail_lane=37, fail_step=0 (flush check).
- Bank whose lane 20 (i=10, clk_inv=0, en_inv=1) ignores EN, seed 16'h0001 → pass=0, fail_lane=20, fail_step = first step with dut_en=1 and d≠held value.
- start re-pulsed while busy, and NUM_STEPS=1 → ignored; exactly 1 APPLY/RISE/FALL; fail_step never exceeds 1.
- rst_n low during RISE → outputs at reset values asynchronously; the next start runs INIT_CHK.
- Second run without reset → FLUSH only (no INIT_CHK); all SR lanes (sr_eff=1) keep sr_val throughout.
